// File: rtl/fb_wb_arbiter.sv
// Write-back arbiter: merges unstallable ALU results with queued load results into the single RF write port.
// Latency: 1 cycle from accepted input to rf_we; loads may wait in a DEPTH-entry FIFO behind ALU traffic.
// Backpressure: ALU is never stalled; lsu_ready = ~full (registered full, same-cycle pop not credited).
//
// Ports: clk/reset_n; ALU result in (alu_valid/alu_rd/alu_data); load result in (lsu_valid/lsu_ready/
// lsu_rd/lsu_data); RF write out (rf_we/rf_waddr/rf_wdata); forwarding lookup (fwd_raddr*/fwd_hit*/
// fwd_data*); busy = FIFO non-empty or write in flight.
module fb_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      fwd_raddr1,
  input  logic [4:0]      fwd_raddr2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]   wptr, rptr, count;
  logic [AW-1:0]   head, tail;
  logic            empty, full;
  logic            alu_take, load_ok, bypass, push;

  assign head  = rptr[AW-1:0];
  assign tail  = wptr[AW-1:0];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign lsu_ready = ~full;
  assign alu_take  = alu_valid && (alu_rd != 5'd0);
  // Loads to x0 are accepted and simply dropped.
  assign load_ok   = lsu_valid && ~full && (lsu_rd != 5'd0);
  assign bypass    = load_ok && ~alu_take && empty;
  assign push      = load_ok && ~bypass;
  assign busy      = ~empty || rf_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      q_vld    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (alu_take) begin
        rf_we    <= 1'b1;
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (!empty) begin
        // A killed head is still popped, but produces no write.
        rf_we <= q_vld[head];
        if (q_vld[head]) begin
          rf_waddr <= q_rd[head];
          rf_wdata <= q_data[head];
        end
        rptr <= rptr + 1'b1;
      end else if (bypass) begin
        rf_we    <= 1'b1;
        rf_waddr <= lsu_rd;
        rf_wdata <= lsu_data;
      end else begin
        rf_we <= 1'b0;
      end

      // The ALU result is younger than every queued load: kill older writes to the same rd.
      // Unoccupied slots may be cleared too; they are ignored until rewritten by a push.
      if (alu_take) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == alu_rd) q_vld[i] <= 1'b0;
        end
      end

      // Later assignment wins over the kill loop for the slot being written this cycle.
      if (push) begin
        q_vld[tail] <= ~(alu_take && (lsu_rd == alu_rd));
        wptr        <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= lsu_rd;
      q_data[tail] <= lsu_data;
    end
  end

  // Forwarding: output stage first, then FIFO oldest-to-youngest so the youngest match wins.
  logic [1:0][4:0]      fwd_ra;
  logic [1:0]           fwd_hit;
  logic [1:0][XLEN-1:0] fwd_dat;
  logic [AW-1:0]        idx;

  assign fwd_ra = {fwd_raddr2, fwd_raddr1};

  always_comb begin
    fwd_hit = '0;
    fwd_dat = '0;
    idx     = '0;
    for (int p = 0; p < 2; p++) begin
      if (fwd_ra[p] != 5'd0) begin
        if (rf_we && (rf_waddr == fwd_ra[p])) begin
          fwd_hit[p] = 1'b1;
          fwd_dat[p] = rf_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = head + AW'(i);
          if ((PW'(i) < count) && q_vld[idx] && (q_rd[idx] == fwd_ra[p])) begin
            fwd_hit[p] = 1'b1;
            fwd_dat[p] = q_data[idx];
          end
        end
      end
    end
  end

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data1 = fwd_dat[0];
  assign fwd_data2 = fwd_dat[1];

endmodule

// File: tb/tb_fb_wb_arbiter.sv
// Testbench for fb_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Inputs driven on the falling edge; outputs compared 1ns later, before the next rising edge.
// Model holds pending loads in a queue and the write-port register as plain variables.
module tb_fb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid, lsu_valid, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd, rf_waddr, fwd_raddr1, fwd_raddr2;
  logic [XLEN-1:0] alu_data, lsu_data, rf_wdata, fwd_data1, fwd_data2;
  logic            rf_we, fwd_hit1, fwd_hit2, busy;

  fb_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        v;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fwd(input logic [4:0] ra, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (ra != 5'd0) begin
      if (m_we && m_waddr == ra) begin h = 1'b1; d = m_wdata; end
      foreach (q[i]) if (q[i].v && q[i].rd == ra) begin h = 1'b1; d = q[i].data; end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic check_outputs();
    logic        h;
    logic [31:0] d;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("lsu_ready", lsu_ready, q.size() < DEPTH);
    chk("busy", busy, (q.size() != 0) || m_we);
    model_fwd(fwd_raddr1, h, d);
    chk("fwd_hit1", fwd_hit1, h);
    chk("fwd_data1", fwd_data1, d);
    model_fwd(fwd_raddr2, h, d);
    chk("fwd_hit2", fwd_hit2, h);
    chk("fwd_data2", fwd_data2, d);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic acc, take, byp;
    ent_t e;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    fwd_raddr1 = r1; fwd_raddr2 = r2;
    #1;
    check_outputs();
    acc  = lv && (q.size() < DEPTH);
    take = av && (ard != 5'd0);
    byp  = 1'b0;
    if (take) begin
      m_we = 1'b1; m_waddr = ard; m_wdata = adat;
      foreach (q[i]) if (q[i].rd == ard) q[i].v = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.v;
      if (e.v) begin m_waddr = e.rd; m_wdata = e.data; end
    end else if (acc && lrd != 5'd0) begin
      m_we = 1'b1; m_waddr = lrd; m_wdata = ldat; byp = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (acc && lrd != 5'd0 && !byp) q.push_back('{rd: lrd, data: ldat, v: !(take && lrd == ard)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rate;
    reset_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    fwd_raddr1 = 0; fwd_raddr2 = 0;
    model_reset();
    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hit1", fwd_hit1, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single ALU write, one-cycle latency then idle.
    step(1, 5, 32'hA5, 0, 0, 0, 0, 0);
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hA5);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    chk("t1_we_off", rf_we, 0);

    // ALU every cycle while 5 loads offered: 4 fit, then full.
    for (int k = 0; k < 4; k++) step(1, 1, k, 1, 5'(10 + k), 32'h100 + k, 0, 0);
    chk("t2_full_rdy", lsu_ready, 0);
    step(1, 1, 9, 1, 20, 32'h999, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_drain_addr", rf_waddr, 10 + k);
      chk("t2_drain_data", rf_wdata, 32'h100 + k);
    end
    idle(2);

    // WAW kill: queued load x7 overwritten by younger ALU x7.
    step(1, 1, 0, 1, 7, 1, 0, 0);
    step(1, 7, 2, 0, 0, 0, 7, 0);
    chk("t3_fwd", fwd_data1, 2);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    chk("t3_killed_we", rf_we, 0);
    idle(2);

    // Two queued loads to x3: youngest forwarded.
    step(1, 1, 0, 1, 3, 32'h11, 0, 3);
    step(1, 2, 0, 1, 3, 32'h22, 0, 3);
    chk("t4_fwd", fwd_data2, 32'h22);
    step(0, 0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 3);
    chk("t4_nohit", fwd_hit2, 0);

    // x0 destinations and lookups.
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    chk("t5_we", rf_we, 0);
    idle(1);

    // Reset with 3 pending loads mid-drain.
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1, 5'(4 + k), 32'h40 + k, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_we", rf_we, 0);
    chk("t6_ready", lsu_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_hit", fwd_hit1, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with varying ALU pressure; small register range to force collisions.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 250) % 3)
        0: rate = 85;
        1: rate = 20;
        default: rate = 50;
      endcase
      step($urandom_range(0, 99) < rate, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
